data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Responder end of the core's data-memory port: accepts ce/we/addr/dataIn requests from the MEM stage
//  and services them from an internal word array after a programmable number of wait states.
//  Drives ready/stall back to the pipeline so the core can be tested against slow memory.
//  Sits in the SoC between the core's MEM-stage outputs and the pipeline stall/data-return inputs.
// PARAMETERS
//  DEPTH        1024  number of 32-bit words in the array (word-addressed by addr[31:2])
//  WAIT_CYCLES  2     wait states inserted before each response (0..15)
// PORTS
//  clk      in   1   system clock, all state on rising edge
//  rst      in   1   asynchronous, active-high reset
//  ce       in   1   request valid; held with addr/we/dataIn/be stable until ready
//  we       in   1   1 = write, 0 = read
//  addr     in   32  byte address; must be word-aligned
//  dataIn   in   32  write data
//  be       in   4   byte enables for writes, be[0] -> bits 7:0
//  dataOut  out  32  read data, valid while ready=1; held until next completion
//  ready    out  1   one-cycle completion pulse
//  err      out  1   with ready: request was misaligned or out of range
//  stall    out  1   combinational: ce & ~ready, to freeze the pipeline
// BEHAVIOUR
//  Reset (async): state=IDLE, wait counter=0, dataOut=0, ready=0, err=0; array contents NOT cleared.
//  FSM states IDLE, WAIT, RESP:
//   IDLE: ce=1 -> latch addr/we/dataIn/be; counter<=WAIT_CYCLES; go WAIT if WAIT_CYCLES>0, else RESP.
//   WAIT: counter decrements each cycle; at counter==1 go RESP.
//   RESP: perform access, ready=1 for exactly this cycle, return to IDLE.
//  Latency: ce sampled in IDLE at edge N -> ready high in cycle after edge N+WAIT_CYCLES+1.
//  Requests are processed only from latched copies; changes on inputs after acceptance are ignored.
//  Write: byte lanes with be[i]=1 updated; be=0000 is legal (no change, still completes).
//  Read: dataOut <= mem[addr[31:2]]; be ignored for reads.
//  Error: addr[1:0]!=0 or addr[31:2]>=DEPTH -> err=1 with ready, write suppressed, dataOut<=0.
//  err=0 on any non-error completion; dataOut unchanged by writes.
//  Back-to-back: ce still high in the cycle after RESP is a new request (accepted in IDLE);
//   minimum spacing between ready pulses is WAIT_CYCLES+2 cycles.
//  ce dropped while in WAIT: access still completes (no abort); ready pulse is emitted regardless.
//  Reset mid-operation: pending access discarded, no array write, ready/err forced 0.
//  stall deasserts in the same cycle ready rises, so the pipeline advances on that edge.
// TESTING
//  1 WAIT_CYCLES=2: write 0xDEADBEEF @0x10 be=1111, then read @0x10 -> ready 3 cycles after
//    acceptance each, dataOut=0xDEADBEEF, err=0.
//  2 Byte enables: write 0x11223344 @0x20, then 0xAABBCCDD be=0101 -> read 0x11BB33DD.
//  3 Errors: read @0x13 and write @(DEPTH*4) -> err=1 with ready, dataOut=0, array word 0 unchanged.
//  4 WAIT_CYCLES=0: hold ce=1 for 4 requests -> ready every 2nd cycle; stall=ce&~ready every cycle.
//  5 Reset mid-write: assert rst during WAIT of write @0x30 -> ready never pulses,
//    later read @0x30 returns the prior value.
//  6 Input change after acceptance: alter addr/dataIn during WAIT -> original latched access performed.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: responder end of the core's data-memory port.
// Accepts a request in IDLE, inserts WAIT_CYCLES wait states, then performs
// the access and pulses ready for one cycle.
//
// Ports:
//   clk      system clock (rising edge)
//   rst      asynchronous active-high reset
//   ce       request valid, inputs held stable until ready
//   we       1 = write, 0 = read
//   addr     byte address (word aligned, word index addr[31:2])
//   dataIn   write data
//   be       write byte enables, be[0] -> bits 7:0
//   dataOut  read data, held until the next completion
//   ready    one-cycle completion pulse
//   err      with ready: misaligned or out-of-range request
//   stall    combinational ce & ~ready
module data_mem_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] dataIn,
    input  logic [3:0]  be,
    output logic [31:0] dataOut,
    output logic        ready,
    output logic        err,
    output logic        stall
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          accept;
    logic          in_resp;

    logic          lat_we;
    logic [31:0]   lat_addr;
    logic [31:0]   lat_din;
    logic [3:0]    lat_be;

    logic          req_err;
    logic          do_write;
    logic [AW-1:0] idx;

    logic [31:0]   mem [DEPTH];

    // State and wait counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state, counter and access strobes
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        in_resp    = 1'b0;
        case (state)
            IDLE: begin
                if (ce) begin
                    accept   = 1'b1;
                    cnt_next = CW'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt - CW'(1);
                // cnt <= 1 rather than == 1 so a zero count can never wrap
                if (cnt <= CW'(1)) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                in_resp    = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request capture; only these copies are used after acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_we   <= 1'b0;
            lat_addr <= '0;
            lat_din  <= '0;
            lat_be   <= '0;
        end else if (accept) begin
            lat_we   <= we;
            lat_addr <= addr;
            lat_din  <= dataIn;
            lat_be   <= be;
        end
    end

    assign req_err  = (lat_addr[1:0] != 2'b00) || (lat_addr[31:2] >= 30'(DEPTH));
    assign idx      = lat_addr[AW+1:2];
    assign do_write = in_resp && lat_we && !req_err && !rst;

    // Word array, deliberately not cleared by reset
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (lat_be[i]) begin
                    mem[idx][8*i +: 8] <= lat_din[8*i +: 8];
                end
            end
        end
    end

    // Registered response; writes leave dataOut untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dataOut <= '0;
            ready   <= 1'b0;
            err     <= 1'b0;
        end else begin
            ready <= in_resp;
            err   <= in_resp && req_err;
            if (in_resp) begin
                if (req_err) begin
                    dataOut <= '0;
                end else if (!lat_we) begin
                    dataOut <= mem[idx];
                end
            end
        end
    end

    assign stall = ce & ~ready;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder: one instance with two wait
// states and one with none, sharing clock, reset and request fields.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce2;
    logic        ce0;
    logic        we;
    logic [31:0] addr;
    logic [31:0] dataIn;
    logic [3:0]  be;
    logic [31:0] dout2;
    logic [31:0] dout0;
    logic        ready2;
    logic        ready0;
    logic        err2;
    logic        err0;
    logic        stall2;
    logic        stall0;

    int total = 0;
    int bad   = 0;

    data_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst(rst), .ce(ce2), .we(we), .addr(addr), .dataIn(dataIn),
        .be(be), .dataOut(dout2), .ready(ready2), .err(err2), .stall(stall2)
    );

    data_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .ce(ce0), .we(we), .addr(addr), .dataIn(dataIn),
        .be(be), .dataOut(dout0), .ready(ready0), .err(err0), .stall(stall0)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request on the two-wait instance; ticks = samples until ready (-1 on timeout)
    task automatic req2(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, output int ticks, output logic [31:0] dout,
                        output logic e, output logic st);
        we = w; addr = a; dataIn = d; be = b; ce2 = 1'b1;
        ticks = -1; dout = 'x; e = 1'bx; st = 1'bx;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ready2) begin
                ticks = i + 1; dout = dout2; e = err2; st = stall2;
                break;
            end
        end
        ce2 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ce2 = 1'b0; ce0 = 1'b0; we = 1'b0; addr = '0; dataIn = '0; be = '0;
        tick(); tick();
        total++; if (ready2 !== 1'b0) begin bad++; $display("FAIL reset_ready2 got=%b exp=0", ready2); end
        total++; if (err2 !== 1'b0) begin bad++; $display("FAIL reset_err2 got=%b exp=0", err2); end
        total++; if (dout2 !== 32'h0) begin bad++; $display("FAIL reset_dout2 got=%h exp=0", dout2); end
        total++; if (ready0 !== 1'b0 || dout0 !== 32'h0) begin bad++; $display("FAIL reset_w0 got=%b/%h exp=0/0", ready0, dout0); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int t; logic [31:0] d; logic e; logic st;
        req2(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, t, d, e, st);
        // accept edge + 2 wait edges + response edge = 4 samples
        total++; if (t !== 4) begin bad++; $display("FAIL basic_wr_latency got=%0d exp=4", t); end
        total++; if (e !== 1'b0 || d !== 32'h0) begin bad++; $display("FAIL basic_wr_resp got=%b/%h exp=0/00000000", e, d); end
        total++; if (st !== 1'b0) begin bad++; $display("FAIL basic_stall_at_ready got=%b exp=0", st); end
        req2(1'b0, 32'h10, 32'h0, 4'h0, t, d, e, st);
        total++; if (t !== 4) begin bad++; $display("FAIL basic_rd_latency got=%0d exp=4", t); end
        total++; if (d !== 32'hDEADBEEF || e !== 1'b0) begin bad++; $display("FAIL basic_rd_data got=%h/%b exp=deadbeef/0", d, e); end
    endtask

    task automatic test_byte_enable();
        int t; logic [31:0] d; logic e; logic st;
        req2(1'b1, 32'h20, 32'h11223344, 4'hF, t, d, e, st);
        req2(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, t, d, e, st);
        req2(1'b0, 32'h20, 32'h0, 4'hF, t, d, e, st);
        total++; if (d !== 32'h11BB33DD) begin bad++; $display("FAIL be_merge got=%h exp=11bb33dd", d); end
        req2(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, t, d, e, st);
        total++; if (t !== 4 || e !== 1'b0) begin bad++; $display("FAIL be_zero_completes got=%0d/%b exp=4/0", t, e); end
        req2(1'b0, 32'h20, 32'h0, 4'h0, t, d, e, st);
        total++; if (d !== 32'h11BB33DD) begin bad++; $display("FAIL be_zero_nochange got=%h exp=11bb33dd", d); end
    endtask

    task automatic test_errors();
        int t; logic [31:0] d; logic e; logic st;
        req2(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, t, d, e, st);
        req2(1'b0, 32'h20, 32'h0, 4'h0, t, d, e, st);
        req2(1'b0, 32'h13, 32'h0, 4'h0, t, d, e, st);
        total++; if (t !== 4 || e !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL err_misaligned got=%0d/%b/%h exp=4/1/00000000", t, e, d); end
        req2(1'b0, 32'h20, 32'h0, 4'h0, t, d, e, st);
        req2(1'b1, 32'h1000, 32'h12345678, 4'hF, t, d, e, st);
        total++; if (e !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL err_range got=%b/%h exp=1/00000000", e, d); end
        tick();
        total++; if (ready2 !== 1'b0 || err2 !== 1'b0) begin bad++; $display("FAIL err_one_cycle got=%b/%b exp=0/0", ready2, err2); end
        req2(1'b0, 32'h0, 32'h0, 4'h0, t, d, e, st);
        total++; if (d !== 32'hCAFEF00D || e !== 1'b0) begin bad++; $display("FAIL err_word0_kept got=%h/%b exp=cafef00d/0", d, e); end
        req2(1'b1, 32'hFFC, 32'h5A5A5A5A, 4'hF, t, d, e, st);
        req2(1'b0, 32'hFFC, 32'h0, 4'h0, t, d, e, st);
        total++; if (d !== 32'h5A5A5A5A || e !== 1'b0) begin bad++; $display("FAIL err_last_word got=%h/%b exp=5a5a5a5a/0", d, e); end
    endtask

    task automatic test_back_to_back();
        logic        exp_rdy;
        logic [31:0] a_tab [4];
        logic [31:0] d_tab [4];
        logic        w_tab [4];
        int          r;
        a_tab[0] = 32'h40; d_tab[0] = 32'h0A0A0A0A; w_tab[0] = 1'b1;
        a_tab[1] = 32'h44; d_tab[1] = 32'h0B0B0B0B; w_tab[1] = 1'b1;
        a_tab[2] = 32'h40; d_tab[2] = 32'h0;        w_tab[2] = 1'b0;
        a_tab[3] = 32'h44; d_tab[3] = 32'h0;        w_tab[3] = 1'b0;
        r = 0;
        we = w_tab[0]; addr = a_tab[0]; dataIn = d_tab[0]; be = 4'hF; ce0 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_rdy = (k % 2 == 0);
            total++; if (ready0 !== exp_rdy) begin bad++; $display("FAIL b2b_ready k=%0d got=%b exp=%b", k, ready0, exp_rdy); end
            total++; if (stall0 !== !exp_rdy) begin bad++; $display("FAIL b2b_stall k=%0d got=%b exp=%b", k, stall0, !exp_rdy); end
            if (exp_rdy) begin
                if (r == 2) begin
                    total++; if (dout0 !== 32'h0A0A0A0A) begin bad++; $display("FAIL b2b_rd0 got=%h exp=0a0a0a0a", dout0); end
                end
                if (r == 3) begin
                    total++; if (dout0 !== 32'h0B0B0B0B) begin bad++; $display("FAIL b2b_rd1 got=%h exp=0b0b0b0b", dout0); end
                end
                r++;
                if (r < 4) begin
                    we = w_tab[r]; addr = a_tab[r]; dataIn = d_tab[r];
                end else begin
                    ce0 = 1'b0;
                end
            end
        end
        ce0 = 1'b0;
    endtask

    task automatic test_reset_mid();
        int t; logic [31:0] d; logic e; logic st;
        req2(1'b1, 32'h30, 32'h0BADCAFE, 4'hF, t, d, e, st);
        we = 1'b1; addr = 32'h30; dataIn = 32'hFFFFFFFF; be = 4'hF; ce2 = 1'b1;
        tick(); tick();
        rst = 1'b1;
        #1;
        total++; if (ready2 !== 1'b0 || err2 !== 1'b0) begin bad++; $display("FAIL rstmid_forced got=%b/%b exp=0/0", ready2, err2); end
        ce2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (ready2 !== 1'b0) begin bad++; $display("FAIL rstmid_no_ready i=%0d got=%b exp=0", i, ready2); end
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (ready2 !== 1'b0) begin bad++; $display("FAIL rstmid_no_late_ready i=%0d got=%b exp=0", i, ready2); end
        end
        req2(1'b0, 32'h30, 32'h0, 4'h0, t, d, e, st);
        total++; if (d !== 32'h0BADCAFE) begin bad++; $display("FAIL rstmid_prior got=%h exp=0badcafe", d); end
    endtask

    task automatic test_input_change();
        int t; logic [31:0] d; logic e; logic st;
        req2(1'b1, 32'h54, 32'h2468ACE0, 4'hF, t, d, e, st);
        we = 1'b1; addr = 32'h50; dataIn = 32'h13579BDF; be = 4'hF; ce2 = 1'b1;
        tick();
        we = 1'b0; addr = 32'h54; dataIn = 32'h0; be = 4'h0;
        t = -1;
        for (int i = 0; i < 20; i++) begin
            if (ready2) begin t = i + 1; break; end
            tick();
        end
        ce2 = 1'b0;
        // acceptance sample plus three more samples
        total++; if (t !== 4 || err2 !== 1'b0) begin bad++; $display("FAIL chg_resp got=%0d/%b exp=4/0", t, err2); end
        req2(1'b0, 32'h50, 32'h0, 4'h0, t, d, e, st);
        total++; if (d !== 32'h13579BDF) begin bad++; $display("FAIL chg_orig_written got=%h exp=13579bdf", d); end
        req2(1'b0, 32'h54, 32'h0, 4'h0, t, d, e, st);
        total++; if (d !== 32'h2468ACE0) begin bad++; $display("FAIL chg_other_kept got=%h exp=2468ace0", d); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_enable();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_input_change();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
